mem_burst_sequencer: RTL and testbench



---
 rtl/mem_burst_sequencer.sv | 166 ++++++++++++++++
 tb/tb_mem_burst_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_sequencer.sv
// Multi-byte little-endian transfer sequencer between the CPU control FSM and an 8-bit memory bus.
// One request moves 1..MAX_BYTES bytes, incrementing or decrementing, with BEAT_CYCLES clocks per byte.
module mem_burst_sequencer #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned BYTE_W      = 8,
    parameter int unsigned MAX_BYTES   = 4,
    parameter int unsigned CNT_W       = 2,
    parameter int unsigned BEAT_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [CNT_W-1:0]              req_count,
    input  logic                          req_dec,
    input  logic [MAX_BYTES*BYTE_W-1:0]   req_wdata,
    output logic                          rsp_valid,
    output logic [MAX_BYTES*BYTE_W-1:0]   rsp_rdata,
    output logic [ADDR_W-1:0]             rsp_end_addr,
    output logic [ADDR_W-1:0]             mem_address,
    input  logic [BYTE_W-1:0]             mem_data_r,
    output logic [BYTE_W-1:0]             mem_data_w,
    output logic                          rw
);

    localparam int unsigned WORD_W = MAX_BYTES * BYTE_W;
    localparam int unsigned BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                dec_q, dec_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [BYTE_W-1:0]   mem_data_w_q, mem_data_w_d;
    logic                rw_q, rw_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WORD_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0]   rsp_end_addr_q, rsp_end_addr_d;

    logic [ADDR_W-1:0]   next_addr;
    logic [WORD_W-1:0]   wdata_shift;

    assign next_addr   = dec_q ? (mem_address_q - ADDR_W'(1)) : (mem_address_q + ADDR_W'(1));
    // Remaining write bytes are kept right-aligned so the current byte is always the low lane.
    assign wdata_shift = wdata_q >> BYTE_W;

    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        idx_d          = idx_q;
        count_d        = count_q;
        dec_d          = dec_q;
        wdata_d        = wdata_q;
        mem_address_d  = mem_address_q;
        mem_data_w_d   = mem_data_w_q;
        rw_d           = rw_q;
        req_ready_d    = req_ready_q;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_end_addr_d = rsp_end_addr_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d       = XFER;
                    req_ready_d   = 1'b0;
                    mem_address_d = req_addr;
                    mem_data_w_d  = req_wdata[BYTE_W-1:0];
                    rw_d          = req_write;
                    wdata_d       = req_wdata;
                    count_d       = req_count;
                    dec_d         = req_dec;
                    idx_d         = '0;
                    beat_d        = '0;
                    rsp_rdata_d   = '0;
                end
            end
            XFER: begin
                beat_d = beat_q + BEAT_W'(1);
                if (beat_q == BEAT_LAST) begin
                    if (!rw_q) begin
                        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
                            if (idx_q == CNT_W'(i)) begin
                                rsp_rdata_d[i*BYTE_W +: BYTE_W] = mem_data_r;
                            end
                        end
                    end
                    if (idx_q == count_q) begin
                        rw_d           = 1'b0;
                        rsp_end_addr_d = next_addr;
                        rsp_valid_d    = 1'b1;
                        state_d        = DONE;
                    end else begin
                        idx_d         = idx_q + CNT_W'(1);
                        beat_d        = '0;
                        mem_address_d = next_addr;
                        wdata_d       = wdata_shift;
                        mem_data_w_d  = wdata_shift[BYTE_W-1:0];
                    end
                end
            end
            DONE: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rw_d        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            beat_q         <= '0;
            idx_q          <= '0;
            count_q        <= '0;
            dec_q          <= 1'b0;
            wdata_q        <= '0;
            mem_address_q  <= '0;
            mem_data_w_q   <= '0;
            rw_q           <= 1'b0;
            req_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_end_addr_q <= '0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            idx_q          <= idx_d;
            count_q        <= count_d;
            dec_q          <= dec_d;
            wdata_q        <= wdata_d;
            mem_address_q  <= mem_address_d;
            mem_data_w_q   <= mem_data_w_d;
            rw_q           <= rw_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_end_addr_q <= rsp_end_addr_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_end_addr = rsp_end_addr_q;
    assign mem_address  = mem_address_q;
    assign mem_data_w   = mem_data_w_q;
    assign rw           = rw_q;

endmodule

// File: tb/tb_mem_burst_sequencer.sv
// Bench for mem_burst_sequencer: three parameterisations share one byte memory and a
// transaction-level reference model (expected bus address per cycle, assembled data, end address).
module tb_mem_burst_sequencer;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic        req_dec;
    logic [15:0] req_addr;
    logic [1:0]  req_count;
    logic [31:0] req_wdata;
    int          sel;

    logic [7:0]  mem [0:65535];

    int n_vec;
    int n_err;

    // DUT0: defaults (4 bytes, 2 cycles/beat)
    logic        rdy0, val0, rw0;
    logic [31:0] rd0;
    logic [15:0] end0, a0;
    logic [7:0]  dw0, dr0;
    // DUT1: 2 bytes, 1 cycle/beat
    logic        rdy1, val1, rw1;
    logic [15:0] rd1;
    logic [15:0] end1, a1;
    logic [7:0]  dw1, dr1;
    // DUT2: 2 bytes, 3 cycles/beat
    logic        rdy2, val2, rw2;
    logic [15:0] rd2;
    logic [15:0] end2, a2;
    logic [7:0]  dw2, dr2;

    logic        o_ready, o_valid, o_rw;
    logic [31:0] o_rdata;
    logic [15:0] o_end, o_addr;
    logic [7:0]  o_dw;

    assign dr0 = mem[a0];
    assign dr1 = mem[a1];
    assign dr2 = mem[a2];

    mem_burst_sequencer #(
        .ADDR_W(16), .BYTE_W(8), .MAX_BYTES(4), .CNT_W(2), .BEAT_CYCLES(2)
    ) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && sel == 0), .req_ready(rdy0),
        .req_write(req_write), .req_addr(req_addr), .req_count(req_count),
        .req_dec(req_dec), .req_wdata(req_wdata),
        .rsp_valid(val0), .rsp_rdata(rd0), .rsp_end_addr(end0),
        .mem_address(a0), .mem_data_r(dr0), .mem_data_w(dw0), .rw(rw0)
    );

    mem_burst_sequencer #(
        .ADDR_W(16), .BYTE_W(8), .MAX_BYTES(2), .CNT_W(1), .BEAT_CYCLES(1)
    ) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && sel == 1), .req_ready(rdy1),
        .req_write(req_write), .req_addr(req_addr), .req_count(req_count[0]),
        .req_dec(req_dec), .req_wdata(req_wdata[15:0]),
        .rsp_valid(val1), .rsp_rdata(rd1), .rsp_end_addr(end1),
        .mem_address(a1), .mem_data_r(dr1), .mem_data_w(dw1), .rw(rw1)
    );

    mem_burst_sequencer #(
        .ADDR_W(16), .BYTE_W(8), .MAX_BYTES(2), .CNT_W(1), .BEAT_CYCLES(3)
    ) u_dut2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && sel == 2), .req_ready(rdy2),
        .req_write(req_write), .req_addr(req_addr), .req_count(req_count[0]),
        .req_dec(req_dec), .req_wdata(req_wdata[15:0]),
        .rsp_valid(val2), .rsp_rdata(rd2), .rsp_end_addr(end2),
        .mem_address(a2), .mem_data_r(dr2), .mem_data_w(dw2), .rw(rw2)
    );

    always_comb begin
        case (sel)
            1: begin
                o_ready = rdy1; o_valid = val1; o_rw = rw1; o_rdata = {16'h0, rd1};
                o_end = end1; o_addr = a1; o_dw = dw1;
            end
            2: begin
                o_ready = rdy2; o_valid = val2; o_rw = rw2; o_rdata = {16'h0, rd2};
                o_end = end2; o_addr = a2; o_dw = dw2;
            end
            default: begin
                o_ready = rdy0; o_valid = val0; o_rw = rw0; o_rdata = rd0;
                o_end = end0; o_addr = a0; o_dw = dw0;
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    function automatic int beats_of(input int s);
        return (s == 1) ? 1 : ((s == 2) ? 3 : 2);
    endfunction

    function automatic logic [15:0] step(input logic [15:0] base, input int off, input logic dec);
        return dec ? (base - 16'(off)) : (base + 16'(off));
    endfunction

    // One complete request on the selected DUT, checked cycle by cycle against the model.
    task automatic xfer(input logic wr, input logic [15:0] addr, input int cnt,
                        input logic dec, input logic [31:0] wd);
        int          bc;
        int          n;
        int          guard;
        logic [31:0] exp_rd;
        logic [15:0] exp_end;
        logic [15:0] a_exp;
        logic [7:0]  wbyte;
        bc      = beats_of(sel);
        n       = (cnt + 1) * bc;
        exp_rd  = '0;
        for (int i = 0; i <= cnt; i++) begin
            if (!wr) exp_rd[8*i +: 8] = mem[step(addr, i, dec)];
        end
        exp_end = step(addr, cnt + 1, dec);

        @(negedge clk);
        req_write = wr; req_addr = addr; req_count = 2'(cnt); req_dec = dec; req_wdata = wd;
        req_valid = 1'b1;
        guard = 0;
        while (!o_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_accept", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            a_exp = step(addr, k / bc, dec);
            check("beat_addr", 32'(o_addr), 32'(a_exp));
            check("beat_rw", 32'(o_rw), 32'(wr));
            check("busy_ready", 32'(o_ready), 32'd0);
            check("early_valid", 32'(o_valid), 32'd0);
            if (wr) begin
                wbyte = wd[8*(k/bc) +: 8];
                check("beat_wdata", 32'(o_dw), 32'(wbyte));
                mem[o_addr] = o_dw;
            end
            @(posedge clk);
            #1;
        end
        check("rsp_valid", 32'(o_valid), 32'd1);
        check("rsp_rdata", o_rdata, exp_rd);
        check("rsp_end_addr", 32'(o_end), 32'(exp_end));
        check("done_rw", 32'(o_rw), 32'd0);
        check("done_ready", 32'(o_ready), 32'd0);
        @(posedge clk);
        #1;
        check("valid_pulse", 32'(o_valid), 32'd0);
        check("idle_ready", 32'(o_ready), 32'd1);
        check("rdata_held", o_rdata, exp_rd);
        check("end_held", 32'(o_end), 32'(exp_end));
        if (wr) begin
            for (int i = 0; i <= cnt; i++) begin
                wbyte = wd[8*i +: 8];
                check("mem_written", 32'(mem[step(addr, i, dec)]), 32'(wbyte));
            end
        end
    endtask

    task automatic rand_xfers(input int num, input int max_cnt);
        logic [15:0] addr;
        for (int t = 0; t < num; t++) begin
            addr = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFE + 16'($urandom_range(0, 3)))
                                               : 16'($urandom);
            xfer(1'($urandom), addr, int'($urandom_range(0, max_cnt)), 1'($urandom), $urandom);
        end
    endtask

    initial begin
        int   g;
        int   seen;
        logic [7:0] eb;
        n_vec = 0;
        n_err = 0;
        sel = 0;
        req_valid = 1'b0; req_write = 1'b0; req_dec = 1'b0;
        req_addr = '0; req_count = '0; req_wdata = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        reset = 1'b1;
        #1;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_rw", 32'(o_rw), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_addr", 32'(o_addr), 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_end", 32'(o_end), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases from the usage scenarios
        mem[16'h0150] = 8'h34; mem[16'h0151] = 8'h12;
        xfer(1'b0, 16'h0150, 1, 1'b0, 32'h0);
        xfer(1'b1, 16'hC000, 1, 1'b0, 32'h0000FFFE);
        mem[16'h0000] = 8'hAA;
        xfer(1'b0, 16'h0000, 0, 1'b1, 32'h0);
        xfer(1'b0, 16'hFFFE, 3, 1'b0, 32'h0);
        xfer(1'b1, 16'h0001, 3, 1'b1, 32'hDEADBEEF);
        xfer(1'b0, 16'h0001, 3, 1'b1, 32'h0);

        // Request held high while busy: ignored until ready returns, then accepted again
        @(negedge clk);
        req_write = 1'b0; req_addr = 16'h2000; req_count = 2'd0; req_dec = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        g = 0; seen = 0;
        while (!o_ready && g < 20) begin
            if (o_valid) seen++;
            @(posedge clk);
            #1;
            g++;
        end
        check("busy_cycles", 32'(g), 32'd3);
        check("busy_one_rsp", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        check("second_accept", 32'(o_ready), 32'd0);
        check("second_addr", 32'(o_addr), 32'h2000);
        req_valid = 1'b0;
        g = 0;
        while (!o_valid && g < 20) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("second_rsp", 32'(o_valid), 32'd1);
        eb = mem[16'h2000];
        check("second_rdata", o_rdata, 32'(eb));
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a write burst
        @(negedge clk);
        req_write = 1'b1; req_addr = 16'h1234; req_count = 2'd3; req_dec = 1'b0;
        req_wdata = 32'h11223344; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_rw", 32'(o_rw), 32'd1);
        reset = 1'b1;
        #1;
        check("async_rw", 32'(o_rw), 32'd0);
        check("async_ready", 32'(o_ready), 32'd1);
        check("async_valid", 32'(o_valid), 32'd0);
        check("async_addr", 32'(o_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (o_valid || o_rw || !o_ready) seen++;
        end
        check("no_rsp_after_reset", 32'(seen), 32'd0);

        rand_xfers(60, 3);

        // Other parameterisations
        sel = 1;
        xfer(1'b0, 16'h0150, 1, 1'b0, 32'h0);
        xfer(1'b1, 16'hFFFF, 1, 1'b0, 32'h0000A55A);
        rand_xfers(30, 1);
        sel = 2;
        xfer(1'b0, 16'h0000, 1, 1'b1, 32'h0);
        xfer(1'b1, 16'h8000, 0, 1'b0, 32'h0000007E);
        rand_xfers(30, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
